// File: rtl/hash_round_engine.sv
// hash_round_engine: iterated A/B/C/D hash round engine with step counter, handshakes and feed-forward chaining
module hash_round_engine #(
    parameter int WORD_W    = 32,
    parameter int MSG_WORDS = 4,
    parameter int STEPS     = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [MSG_WORDS*WORD_W-1:0] msg_i,
    input  logic [4*WORD_W-1:0]         iv_i,
    input  logic                        first_i,
    input  logic                        abort_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [4*WORD_W-1:0]         digest_o,
    output logic                        busy_o
);
    localparam int RL = STEPS / 4;
    localparam int SW = $clog2(STEPS);
    localparam int unsigned S_TAB [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    typedef enum logic [2:0] {IDLE, LOAD, RUN, FINAL, OUT} state_e;

    state_e                      state_q, state_d;
    logic [WORD_W-1:0]           a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [4*WORD_W-1:0]         blk_iv_q, blk_iv_d, chain_q, chain_d;
    logic [MSG_WORDS*WORD_W-1:0] msg_q, msg_d;
    logic [SW-1:0]               step_q, step_d;

    int                idx, rnd, gix;
    int unsigned       sh;
    logic [3:0]        si;
    logic [WORD_W-1:0] f, m, k, tmp, b_new;

    // One compression step on the current A/B/C/D, selected by step index and round
    always_comb begin
        idx   = int'(step_q);
        rnd   = idx / RL;
        gix   = (rnd == 0 ? idx : rnd == 1 ? 5 * idx + 1 : rnd == 2 ? 3 * idx + 5 : 7 * idx) % MSG_WORDS;
        si    = 4'(4 * rnd + idx % 4);
        sh    = S_TAB[si] % WORD_W;
        f     = rnd == 0 ? (b_q & c_q) | (~b_q & d_q) :
                rnd == 1 ? (d_q & b_q) | (~d_q & c_q) :
                rnd == 2 ? b_q ^ c_q ^ d_q : c_q ^ (b_q | ~d_q);
        m     = WORD_W'(msg_q >> ((MSG_WORDS - 1 - gix) * WORD_W));
        k     = WORD_W'(32'(idx + 1) * 32'h9E3779B9);
        tmp   = a_q + f + m + k;
        b_new = b_q + WORD_W'(({tmp, tmp} << sh) >> WORD_W);
    end

    // Next state, handshake outputs and register updates; abort always returns to IDLE
    always_comb begin
        in_ready_o           = state_q == IDLE;
        out_valid_o          = state_q == OUT;
        busy_o               = state_q inside {LOAD, RUN, FINAL};
        digest_o             = chain_q;
        state_d              = state_q;
        {a_d, b_d, c_d, d_d} = {a_q, b_q, c_q, d_q};
        blk_iv_d             = blk_iv_q;
        chain_d              = chain_q;
        msg_d                = msg_q;
        step_d               = step_q;
        if (abort_i) begin
            state_d = IDLE;
        end else if (state_q == IDLE && in_valid_i) begin
            state_d  = LOAD;
            msg_d    = msg_i;
            blk_iv_d = first_i ? iv_i : chain_q;
        end else if (state_q == LOAD) begin
            state_d              = RUN;
            {a_d, b_d, c_d, d_d} = blk_iv_q;
            step_d               = '0;
        end else if (state_q == RUN) begin
            {a_d, b_d, c_d, d_d} = {d_q, b_new, b_q, c_q};
            state_d              = step_q == SW'(STEPS - 1) ? FINAL : RUN;
            step_d               = step_q == SW'(STEPS - 1) ? step_q : step_q + 1'b1;
        end else if (state_q == FINAL) begin
            state_d = OUT;
            chain_d = {a_q + blk_iv_q[4*WORD_W-1 -: WORD_W], b_q + blk_iv_q[3*WORD_W-1 -: WORD_W],
                       c_q + blk_iv_q[2*WORD_W-1 -: WORD_W], d_q + blk_iv_q[WORD_W-1:0]};
        end else if (state_q == OUT && out_ready_i) begin
            state_d = IDLE;
        end
    end

    // State, working registers, block IV, chain and message registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            blk_iv_q <= '0;
            chain_q  <= '0;
            msg_q    <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            blk_iv_q <= blk_iv_d;
            chain_q  <= chain_d;
            msg_q    <= msg_d;
            step_q   <= step_d;
        end
    end
endmodule

// File: tb/tb_hash_round_engine.sv
// tb_hash_round_engine: scoreboard bench for hash_round_engine (default and 8-bit/4-step instances)
module tb_hash_round_engine;
    logic clk = 0, rst_n = 0;
    logic in_valid = 0, first = 0, abort = 0, out_ready = 0;
    logic [127:0] msg = '0, iv = '0;
    logic in_ready, out_valid, busy;
    logic [127:0] digest;
    logic s_in_valid = 0, s_first = 0, s_abort = 0, s_out_ready = 0;
    logic [31:0] s_msg = '0, s_iv = '0;
    logic s_in_ready, s_out_valid, s_busy;
    logic [31:0] s_digest;
    int errs = 0, checks = 0;
    logic [127:0] exp_q[$];
    logic [127:0] chain_m = '0;

    hash_round_engine dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .msg_i(msg), .iv_i(iv), .first_i(first), .abort_i(abort),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .digest_o(digest), .busy_o(busy)
    );

    hash_round_engine #(.WORD_W(8), .MSG_WORDS(4), .STEPS(4)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .msg_i(s_msg), .iv_i(s_iv), .first_i(s_first), .abort_i(s_abort),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .digest_o(s_digest), .busy_o(s_busy)
    );

    always #5 clk = ~clk;

    // Reference model: words held in 32-bit containers and masked to w bits
    function automatic logic [127:0] model(input logic [511:0] mf, input logic [127:0] ivv,
                                           input int w, input int mw, input int st);
        logic [31:0] mk, a, b, c, d, f, t, k, x;
        logic [31:0] mm [16];
        logic [31:0] h [4];
        logic [31:0] v [4];
        logic [127:0] res;
        int rl, r, g, s;
        int sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
        mk = w == 32 ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
        for (int j = 0; j < 16; j++) mm[j] = j < mw ? 32'(mf >> ((mw - 1 - j) * w)) & mk : 32'd0;
        for (int j = 0; j < 4; j++) h[j] = 32'(ivv >> ((3 - j) * w)) & mk;
        a = h[0]; b = h[1]; c = h[2]; d = h[3];
        rl = st / 4;
        for (int i = 0; i < st; i++) begin
            r = i / rl;
            case (r)
                0: begin f = (b & c) | (~b & d); g = i; end
                1: begin f = (d & b) | (~d & c); g = 5 * i + 1; end
                2: begin f = b ^ c ^ d; g = 3 * i + 5; end
                default: begin f = c ^ (b | ~d); g = 7 * i; end
            endcase
            f = f & mk;
            g = g % mw;
            k = (32'(i + 1) * 32'h9E3779B9) & mk;
            s = sh[4 * r + i % 4] % w;
            t = (a + f + mm[g] + k) & mk;
            x = ((t << s) | (t >> (w - s))) & mk;
            {a, b, c, d} = {d, (b + x) & mk, b, c};
        end
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        res = '0;
        for (int j = 0; j < 4; j++) res = (res << w) | 128'((v[j] + h[j]) & mk);
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a block, wait for acceptance, scramble inputs afterwards, push expectation
    task automatic send(input logic [127:0] m, input logic [127:0] v, input logic f);
        int n = 0;
        msg = m; iv = v; first = f; in_valid = 1;
        while (!in_ready && n < 200) begin tick(); n++; end
        tick();
        in_valid = 0; msg = rnd128(); iv = rnd128(); first = 1'($urandom);
        exp_q.push_back(model({384'b0, m}, f ? v : chain_m, 32, 4, 64));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin tick(); lat++; end
        if (!out_valid) lat = -1;
    endtask

    task automatic take(output logic [127:0] e);
        e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        chain_m = e;
    endtask

    task automatic consume();
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errs++; $display("FAIL reset_flags got=%b exp=100", {in_ready, out_valid, busy});
        end
        checks++;
        if (digest !== '0) begin errs++; $display("FAIL reset_digest got=%h exp=0", digest); end
        checks++;
        if ({s_in_ready, s_out_valid, s_busy, s_digest} !== {3'b100, 32'h0}) begin
            errs++; $display("FAIL reset_small got=%b/%h exp=100/0", {s_in_ready, s_out_valid, s_busy}, s_digest);
        end
        rst_n = 1;
        tick();
        checks++;
        if ({in_ready, busy} !== 2'b10) begin errs++; $display("FAIL reset_idle got=%b exp=10", {in_ready, busy}); end
    endtask

    task automatic test_vector();
        logic [31:0] sq[$];
        logic [127:0] e;
        logic [31:0] m, v, got;
        int lat;
        for (int t = 0; t < 3; t++) begin
            m = t == 0 ? 32'h0 : $urandom;
            v = t == 0 ? 32'h0 : $urandom;
            s_msg = m; s_iv = v; s_first = 1; s_in_valid = 1;
            tick();
            s_in_valid = 0; s_msg = $urandom; s_iv = $urandom;
            e = model({480'b0, m}, {96'b0, v}, 8, 4, 4);
            sq.push_back(e[31:0]);
            checks++;
            if (s_busy !== 1'b1) begin errs++; $display("FAIL small_busy got=%b exp=1", s_busy); end
            lat = 0;
            while (!s_out_valid && lat < 50) begin tick(); lat++; end
            checks++;
            if (lat !== 6) begin errs++; $display("FAIL small_latency got=%0d exp=6", lat); end
            got = sq.size() > 0 ? sq.pop_front() : 32'h0;
            checks++;
            if (s_digest !== got) begin errs++; $display("FAIL small_digest got=%h exp=%h", s_digest, got); end
            if (t == 0) begin
                checks++;
                if (s_digest !== 32'hDC8007C0) begin
                    errs++; $display("FAIL small_known got=%h exp=dc8007c0", s_digest);
                end
            end
            s_out_ready = 1;
            tick();
            s_out_ready = 0;
        end
    endtask

    task automatic test_default();
        logic [127:0] e;
        int lat;
        for (int t = 0; t < 3; t++) begin
            send(rnd128(), rnd128(), 1);
            wait_out(lat);
            checks++;
            if (lat !== 66) begin errs++; $display("FAIL default_latency got=%0d exp=66", lat); end
            take(e);
            checks++;
            if (digest !== e) begin errs++; $display("FAIL default_digest got=%h exp=%h", digest, e); end
            consume();
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errs++; $display("FAIL default_release got=%b exp=10", {in_ready, out_valid});
            end
        end
    endtask

    task automatic test_chain();
        logic [127:0] e;
        int lat;
        for (int t = 0; t < 4; t++) begin
            send(rnd128(), rnd128(), t == 0 || t == 3);
            wait_out(lat);
            take(e);
            checks++;
            if (digest !== e || lat !== 66) begin
                errs++; $display("FAIL chain_%0d got=%h lat=%0d exp=%h lat=66", t, digest, lat, e);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] e;
        int lat;
        send(rnd128(), rnd128(), 1);
        wait_out(lat);
        take(e);
        in_valid = 1; msg = rnd128(); first = 1;
        for (int t = 0; t < 20; t++) begin
            checks++;
            if (digest !== e || {in_ready, out_valid} !== 2'b01) begin
                errs++; $display("FAIL bp_hold_%0d got=%h/%b exp=%h/01", t, digest, {in_ready, out_valid}, e);
            end
            tick();
        end
        in_valid = 0;
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errs++; $display("FAIL bp_release got=%b exp=100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_abort();
        logic [127:0] e;
        logic seen;
        int lat;
        in_valid = 1; abort = 1; msg = rnd128(); first = 1;
        tick();
        in_valid = 0; abort = 0;
        checks++;
        if ({in_ready, busy} !== 2'b10) begin errs++; $display("FAIL abort_idle got=%b exp=10", {in_ready, busy}); end
        send(rnd128(), rnd128(), 1);
        repeat (31) tick();
        checks++;
        if (busy !== 1'b1) begin errs++; $display("FAIL abort_busy got=%b exp=1", busy); end
        abort = 1;
        tick();
        abort = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        checks++;
        if ({in_ready, busy} !== 2'b10) begin errs++; $display("FAIL abort_run got=%b exp=10", {in_ready, busy}); end
        seen = 0;
        repeat (80) begin tick(); seen |= out_valid; end
        checks++;
        if (seen !== 1'b0) begin errs++; $display("FAIL abort_no_out got=%b exp=0", seen); end
        send(rnd128(), rnd128(), 0);
        wait_out(lat);
        take(e);
        checks++;
        if (digest !== e || lat !== 66) begin
            errs++; $display("FAIL abort_chain got=%h lat=%0d exp=%h lat=66", digest, lat, e);
        end
        abort = 1; out_ready = 1;
        tick();
        abort = 0; out_ready = 0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errs++; $display("FAIL abort_out got=%b exp=10", {in_ready, out_valid});
        end
        send(rnd128(), rnd128(), 0);
        wait_out(lat);
        take(e);
        checks++;
        if (digest !== e) begin errs++; $display("FAIL abort_out_chain got=%h exp=%h", digest, e); end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [127:0] e;
        int lat;
        send(rnd128(), rnd128(), 1);
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1) begin errs++; $display("FAIL rstmid_busy got=%b exp=1", busy); end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || digest !== '0) begin
            errs++; $display("FAIL rstmid_async got=%b/%h exp=100/0", {in_ready, out_valid, busy}, digest);
        end
        #2 rst_n = 1;
        exp_q.delete();
        chain_m = '0;
        tick();
        checks++;
        if ({in_ready, busy} !== 2'b10) begin errs++; $display("FAIL rstmid_idle got=%b exp=10", {in_ready, busy}); end
        send(rnd128(), rnd128(), 0);
        wait_out(lat);
        take(e);
        checks++;
        if (digest !== e || lat !== 66) begin
            errs++; $display("FAIL rstmid_zero_chain got=%h lat=%0d exp=%h lat=66", digest, lat, e);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_vector();
        test_default();
        test_chain();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/hash_round_engine.md
Name: hash_round_engine

Overview:
- Parametrised successor of the four-register A/B/C/D MD5-style round datapath.
- Contains its own step counter, control FSM and valid/ready handshakes. It no longer needs an external controller or random word selection.
- Computes one step per cycle over a configurable number of steps, word width and message-word count.
- Supports multi-block chaining (feed-forward add of the block's IV into the digest) and a synchronous abort.
- Sits between the message loader and the digest consumer in the hash subsystem.

Parameters:
- WORD_W, 32, register/word width in bits; legal 8..32.
- MSG_WORDS, 4, message words per block; power of two, 2..16.
- STEPS, 64, steps per block; multiple of 4, 4..64. Round length RL = STEPS/4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  block offered.
- in_ready  out  1  engine can accept a block.
- msg  in  MSG_WORDS*WORD_W  block; M0 = msg[top -: WORD_W], words descending.
- iv  in  4*WORD_W  initial {A,B,C,D}, used when first=1.
- first  in  1  sampled with msg; 1 = use iv, 0 = use chained digest.
- abort  in  1  synchronous abort.
- out_valid  out  1  digest available.
- out_ready  in  1  consumer accepts digest.
- digest  out  4*WORD_W  {A,B,C,D} after feed-forward.
- busy  out  1  high in LOAD/RUN/FINAL.

Behaviour:
- Async reset (rst=0):
  - State IDLE; A,B,C,D, chain register, message registers and step counter go to 0.
  - in_ready=1, out_valid=0, busy=0, digest=0.
- FSM states: IDLE, LOAD, RUN, FINAL, OUT.
  - IDLE: in_ready=1. On in_valid&in_ready, latch msg and first, then go to LOAD. This is edge E0.
  - LOAD (E1): A..D <= (first ? iv : chain); blk_iv <= the same value; step <= 0.
  - RUN: one step per edge for i=0..STEPS-1. After step STEPS-1, go to FINAL.
  - FINAL: digest/chain <= per-word (A..D + blk_iv) mod 2^WORD_W; go to OUT.
  - OUT: out_valid=1, digest stable. On out_ready, go to IDLE; the chain register is retained.
- Latency: out_valid rises STEPS+2 edges after E0 (66 edges by default). in_ready is high only in IDLE, so a new block can be accepted on the cycle after the OUT handshake.
- Step i definitions:
  - Round r = i/RL.
  - F by round: r0 = (B&C)|(~B&D); r1 = (D&B)|(~D&C); r2 = B^C^D; r3 = C^(B|~D).
  - Message index g = (i, 5i+1, 3i+5, 7i for r0..r3) mod MSG_WORDS.
  - Constant K_i = ((i+1)*32'h9E3779B9) mod 2^WORD_W.
  - Rotate amount s = S[r][i mod 4] mod WORD_W, with S = {7,12,17,22}, {5,9,14,20}, {4,11,16,23}, {6,10,15,21}.
  - Update: tmp = A+F+M[g]+K_i (mod 2^WORD_W); A<=D, D<=C, C<=B, B<=B+rotl(tmp,s).
  - All additions wrap modulo 2^WORD_W.
- Step counter: width clog2(STEPS). It wraps to 0 only via LOAD; it never advances outside RUN.
- abort:
  - Any non-OUT state goes to IDLE next edge; out_valid stays 0.
  - The chain register is unchanged, so a partially computed block never corrupts the chain.
  - abort in OUT: drop out_valid, go to IDLE, keep the chain updated.
  - abort in IDLE: no effect; abort wins over a simultaneous in_valid.
- Simultaneous out_ready and abort in OUT: single transition to IDLE.
- in_valid with first=0 before any completed block: chain = 0 is used.
- msg/iv changes after acceptance are ignored.

Test Plan:
- Reset: drive rst=0 mid-RUN -> immediately in_ready=1, out_valid=0, busy=0, digest=0; after release, IDLE.
- Vector (WORD_W=8, MSG_WORDS=4, STEPS=4): iv=0, msg=0, first=1 -> out_valid exactly 6 edges after accept, digest=32'hDC8007C0.
- Default params: random msg/iv with first=1 -> digest matches the C reference model bit-exact; out_valid 66 edges after accept.
- Chaining: block1 first=1, block2 first=0 -> block2 digest equals model(block2, IV = block1 digest); block3 first=1 ignores the chain.
- Backpressure: hold out_ready=0 for 20 cycles -> digest stable, in_ready=0, in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
- Abort at step 30, then a first=0 block -> result equals a chain from the last completed block, with no out_valid pulse for the aborted block.
